// File: rtl/soc_system_pio_poll_master_if.sv
// Avalon-MM read-only bus between the poll master and the polled slave.
interface soc_system_pio_poll_master_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/soc_system_pio_poll_master.sv
// Polls one Avalon-MM slave register until (data & mask) == (match & mask).
// Define POLL_TIMEOUT_EN to end the poll with a timeout pulse after max_polls reads.
module soc_system_pio_poll_master #(
    parameter int ADDR_W       = 2,
    parameter int READ_LATENCY = 1,
    parameter int GAP_W        = 16,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soc_system_pio_poll_master_if.master avm,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_poll_addr,
    input  logic [31:0]          i_mask,
    input  logic [31:0]          i_match,
    input  logic [GAP_W-1:0]     i_interval,
    input  logic [CNT_W-1:0]     i_max_polls,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [31:0]          o_last_data
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_CHK, S_GAP} state_t;
    localparam int LAT_W = 3;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_mask;
    logic [31:0]       r_match;
    logic [GAP_W-1:0]  r_interval;
    logic [GAP_W-1:0]  r_gap;
    logic [CNT_W-1:0]  r_att;
    logic [LAT_W-1:0]  r_lat;
    logic [31:0]       r_last_data;
    logic              r_read;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic              w_hit;
    logic              w_limit;

    // Match is judged on the incoming word so done can be registered into CHK.
    assign w_hit = ((avm.avm_readdata ^ r_match) & r_mask) == 32'h0;

`ifdef POLL_TIMEOUT_EN
    logic [CNT_W-1:0] r_max;
    assign w_limit = (r_max != '0) && (r_att == r_max);
`else
    logic w_unused;
    assign w_unused = ^{i_max_polls, r_att};
    assign w_limit  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_mask      <= '0;
            r_match     <= '0;
            r_interval  <= '0;
            r_gap       <= '0;
            r_att       <= '0;
            r_lat       <= '0;
            r_last_data <= '0;
            r_read      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            r_max       <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr     <= i_poll_addr;
                        r_mask     <= i_mask;
                        r_match    <= i_match;
                        r_interval <= i_interval;
`ifdef POLL_TIMEOUT_EN
                        r_max      <= i_max_polls;
`endif
                        r_att      <= '0;
                        r_read     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (!avm.avm_waitrequest) begin
                        r_read  <= 1'b0;
                        if (r_att != '1)
                            r_att <= r_att + 1'b1;
                        r_lat   <= LAT_W'(READ_LATENCY - 1);
                        r_state <= S_LAT;
                    end
                end
                S_LAT: begin
                    if (r_lat == '0) begin
                        r_last_data <= avm.avm_readdata;
                        if (w_hit)
                            r_done <= 1'b1;
                        else if (w_limit)
                            r_timeout <= 1'b1;
                        r_state <= S_CHK;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_CHK: begin
                    if (r_done || r_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_interval == '0) begin
                        r_read  <= 1'b1;
                        r_state <= S_RD;
                    end else begin
                        r_gap   <= r_interval;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // GAP occupies exactly interval cycles before the next read.
                    if (r_gap == GAP_W'(1)) begin
                        r_read  <= 1'b1;
                        r_state <= S_RD;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm.avm_address = r_addr;
    assign avm.avm_read    = r_read;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_timeout       = r_timeout;
    assign o_last_data     = r_last_data;
endmodule

// File: tb/tb_soc_system_pio_poll_master.sv
// Bench for soc_system_pio_poll_master: scripted and randomized polls against a modelled slave.
module tb_soc_system_pio_poll_master;
    localparam int ADDR_W = 2;
    localparam int RL     = 1;
    localparam int GAP_W  = 16;
    localparam int CNT_W  = 16;
`ifdef POLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] poll_addr;
    logic [31:0]       mask;
    logic [31:0]       match;
    logic [GAP_W-1:0]  interval;
    logic [CNT_W-1:0]  max_polls;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [31:0]       last_data;

    soc_system_pio_poll_master_if #(.ADDR_W(ADDR_W)) bus ();

    soc_system_pio_poll_master #(
        .ADDR_W(ADDR_W), .READ_LATENCY(RL), .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avm(bus),
        .i_start(start), .i_poll_addr(poll_addr), .i_mask(mask), .i_match(match),
        .i_interval(interval), .i_max_polls(max_polls),
        .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_last_data(last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Slave script: response word and waitrequest length per read of the current poll.
    logic [31:0] cfg_resp [16];
    int          cfg_wait [16];
    int          cfg_n;
    int          base_acc;
    int          base_wait;

    int          acc_idx = 0;
    int          wait_idx = 0;
    int          s_k = 0;
    int          s_wcnt = 0;
    bit          s_in_read = 1'b0;
    logic        s_rd = 1'b0;
    logic        s_wr = 1'b0;
    logic [31:0] s_resp = '0;

    always @(negedge clk) begin
        s_rd = bus.avm_read;
        s_wr = bus.avm_waitrequest;
    end

    // Readdata is valid only RL cycles after acceptance; other cycles carry junk.
    always @(posedge clk) begin
        int ai;
        int wi;
        #1;
        if (!reset_n) begin
            s_in_read = 1'b0;
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdata = $urandom;
        end else begin
            if (s_rd && !s_wr) begin
                ai = acc_idx - base_acc;
                s_resp = (ai >= 0 && ai < cfg_n) ? cfg_resp[ai] : $urandom;
                acc_idx++;
                s_k = 0;
            end
            s_k++;
            bus.avm_readdata = (s_k == RL) ? s_resp : $urandom;
            if (bus.avm_read) begin
                if (!s_in_read) begin
                    s_in_read = 1'b1;
                    wi = wait_idx - base_wait;
                    s_wcnt = (wi >= 0 && wi < cfg_n) ? cfg_wait[wi] : 0;
                    wait_idx++;
                end else if (s_wcnt > 0) begin
                    s_wcnt--;
                end
                bus.avm_waitrequest = (s_wcnt > 0);
            end else begin
                s_in_read = 1'b0;
                bus.avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // Observations of one poll sequence, cycle 1 = first cycle after the start edge.
    int          ob_acc, ob_done_cyc, ob_to_cyc, ob_done_cnt, ob_to_cnt, ob_both;
    int          ob_addr_bad, ob_busy_end, ob_first_run;
    bit          ob_hang;
    logic [31:0] ob_ld;
    int          ob_rise [$];

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            cfg_resp[i] = '0;
            cfg_wait[i] = 0;
        end
        cfg_n = 0;
    endtask

    task automatic run_poll(input logic [ADDR_W-1:0] a, input logic [31:0] m, input logic [31:0] mt,
                            input int iv, input int mp, input int stop_reads,
                            input int abort_cyc, input int poke_cyc);
        int   c;
        logic prev_rd;
        ob_acc = 0; ob_done_cnt = 0; ob_to_cnt = 0; ob_both = 0; ob_addr_bad = 0;
        ob_first_run = 0; ob_hang = 1'b0; ob_ld = '0;
        ob_done_cyc = -1; ob_to_cyc = -1; ob_busy_end = -1;
        ob_rise.delete();
        base_acc = acc_idx;
        base_wait = wait_idx;
        poll_addr = a; mask = m; match = mt;
        interval = GAP_W'(iv); max_polls = CNT_W'(mp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        prev_rd = 1'b0;
        forever begin
            if (bus.avm_read) begin
                if (!prev_rd) ob_rise.push_back(c);
                if (ob_rise.size() == 1) ob_first_run++;
            end
            if (busy && bus.avm_address !== a) ob_addr_bad++;
            if (bus.avm_read && !bus.avm_waitrequest) ob_acc++;
            if (done === 1'b1) begin ob_done_cnt++; ob_done_cyc = c; ob_ld = last_data; end
            if (timeout === 1'b1) begin ob_to_cnt++; ob_to_cyc = c; ob_ld = last_data; end
            if (done === 1'b1 && timeout === 1'b1) ob_both++;
            prev_rd = bus.avm_read;
            if (busy !== 1'b1) begin ob_busy_end = c; break; end
            if ((stop_reads > 0 && ob_acc >= stop_reads) || c == abort_cyc) break;
            if (c >= 3000) begin ob_hang = 1'b1; break; end
            if (c == poke_cyc) begin start = 1'b1; poll_addr = ~a; end
            else begin start = 1'b0; poll_addr = a; end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        poll_addr = a;
    endtask

    // Expected reads, outcome, end cycle and captured word from the scripted slave.
    function automatic void model(input logic [31:0] m, input logic [31:0] mt, input int iv, input int mp,
                                  output int n, output bit hit, output int t, output logic [31:0] ld);
        n = 0; hit = 1'b0; t = 0; ld = '0;
        for (int i = 0; i < cfg_n; i++) begin
            n = i + 1;
            t += cfg_wait[i] + RL + 2 + ((i > 0) ? iv : 0);
            ld = cfg_resp[i];
            if (((cfg_resp[i] ^ mt) & m) == 32'h0) begin hit = 1'b1; return; end
            if (TO_EN && mp != 0 && n == mp) return;
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.avm_read, busy, done, timeout} !== 4'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {bus.avm_read, busy, done, timeout});
        end
        vectors++;
        if (bus.avm_address !== '0) begin
            miscompares++; $display("FAIL reset_addr: got %0h want 0", bus.avm_address);
        end
        vectors++;
        if (last_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_last_data: got %0h want 0", last_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        clear_cfg(); cfg_n = 1; cfg_resp[0] = 32'h1;
        run_poll(2'd2, 32'h1, 32'h1, 3, 0, 0, -1, -1);
        vectors++;
        if (ob_acc !== 1) begin miscompares++; $display("FAIL single_reads: got %0d want 1", ob_acc); end
        vectors++;
        if (ob_done_cyc !== 3) begin miscompares++; $display("FAIL single_done_cycle: got %0d want 3", ob_done_cyc); end
        vectors++;
        if (ob_ld !== 32'h1) begin miscompares++; $display("FAIL single_last_data: got %0h want 1", ob_ld); end
        vectors++;
        if (ob_busy_end !== 4) begin miscompares++; $display("FAIL single_busy_drop: got %0d want 4", ob_busy_end); end
        vectors++;
        if (ob_to_cnt !== 0) begin miscompares++; $display("FAIL single_timeout: got %0d want 0", ob_to_cnt); end
    endtask

    task automatic test_retry();
        int n, t; bit hit; logic [31:0] ld;
        clear_cfg(); cfg_n = 4;
        for (int i = 0; i < 4; i++) cfg_resp[i] = (i == 3) ? 32'h1 : 32'h0;
        model(32'h1, 32'h1, 4, 0, n, hit, t, ld);
        run_poll(2'd1, 32'h1, 32'h1, 4, 0, 0, -1, -1);
        vectors++;
        if (ob_acc !== 4) begin miscompares++; $display("FAIL retry_reads: got %0d want 4", ob_acc); end
        vectors++;
        if (ob_rise.size() !== 4) begin miscompares++; $display("FAIL retry_pulses: got %0d want 4", ob_rise.size()); end
        for (int i = 1; i < ob_rise.size(); i++) begin
            vectors++;
            if (ob_rise[i] - ob_rise[i-1] - 1 !== RL + 1 + 4) begin
                miscompares++;
                $display("FAIL retry_spacing: got %0d want %0d", ob_rise[i] - ob_rise[i-1] - 1, RL + 1 + 4);
            end
        end
        vectors++;
        if (ob_done_cyc !== t) begin miscompares++; $display("FAIL retry_done_cycle: got %0d want %0d", ob_done_cyc, t); end
        vectors++;
        if (ob_done_cnt !== 1) begin miscompares++; $display("FAIL retry_done_count: got %0d want 1", ob_done_cnt); end
    endtask

    task automatic test_waitreq();
        clear_cfg(); cfg_n = 1; cfg_resp[0] = 32'hA5A5_0001; cfg_wait[0] = 5;
        run_poll(2'd3, 32'hF, 32'h1, 0, 0, 0, -1, -1);
        vectors++;
        if (ob_first_run !== 6) begin miscompares++; $display("FAIL wait_read_hold: got %0d want 6", ob_first_run); end
        vectors++;
        if (ob_addr_bad !== 0) begin miscompares++; $display("FAIL wait_addr_stable: got %0d bad cycles want 0", ob_addr_bad); end
        vectors++;
        if (ob_ld !== 32'hA5A5_0001) begin miscompares++; $display("FAIL wait_last_data: got %0h want a5a50001", ob_ld); end
        vectors++;
        if (ob_done_cyc !== 8) begin miscompares++; $display("FAIL wait_done_cycle: got %0d want 8", ob_done_cyc); end
    endtask

    task automatic test_timeout();
        int n, t; bit hit; logic [31:0] ld;
        clear_cfg(); cfg_n = 16;
        model(32'h1, 32'h1, 2, 3, n, hit, t, ld);
        run_poll(2'd0, 32'h1, 32'h1, 2, 3, 6, -1, -1);
        vectors++;
        if (ob_hang !== 1'b0) begin miscompares++; $display("FAIL limit_hang: got %0d want 0", ob_hang); end
        vectors++;
        if (ob_done_cnt !== 0) begin miscompares++; $display("FAIL limit_done: got %0d want 0", ob_done_cnt); end
`ifdef POLL_TIMEOUT_EN
        vectors++;
        if (ob_acc !== 3) begin miscompares++; $display("FAIL limit_reads: got %0d want 3", ob_acc); end
        vectors++;
        if (ob_to_cnt !== 1) begin miscompares++; $display("FAIL limit_timeout: got %0d want 1", ob_to_cnt); end
        vectors++;
        if (ob_to_cyc !== t) begin miscompares++; $display("FAIL limit_timeout_cycle: got %0d want %0d", ob_to_cyc, t); end
        vectors++;
        if (ob_busy_end !== t + 1) begin miscompares++; $display("FAIL limit_busy_drop: got %0d want %0d", ob_busy_end, t + 1); end
`else
        vectors++;
        if (ob_acc !== 6) begin miscompares++; $display("FAIL unlimited_reads: got %0d want 6", ob_acc); end
        vectors++;
        if (ob_to_cnt !== 0) begin miscompares++; $display("FAIL unlimited_timeout: got %0d want 0", ob_to_cnt); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL unlimited_busy: got %b want 1", busy); end
        do_reset();
`endif
    endtask

    task automatic test_reset_gap();
        int n, t; bit hit; logic [31:0] ld;
        clear_cfg(); cfg_n = 16;
        for (int i = 0; i < 16; i++) cfg_resp[i] = 32'hFFFF_FFFE;
        run_poll(2'd1, 32'h1, 32'h1, 10, 0, 0, 6, -1);
        vectors++;
        if (last_data !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL gap_pre_data: got %0h want fffffffe", last_data); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.avm_read, busy, done, timeout} !== 4'b0) begin
            miscompares++; $display("FAIL gap_reset_ctrl: got %b want 0000", {bus.avm_read, busy, done, timeout});
        end
        vectors++;
        if (bus.avm_address !== '0 || last_data !== 32'h0) begin
            miscompares++; $display("FAIL gap_reset_data: got addr %0h data %0h want 0 0", bus.avm_address, last_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_cfg(); cfg_n = 2; cfg_resp[0] = 32'h10; cfg_resp[1] = 32'h13;
        model(32'h3, 32'h3, 1, 0, n, hit, t, ld);
        run_poll(2'd2, 32'h3, 32'h3, 1, 0, 0, -1, -1);
        vectors++;
        if (ob_acc !== n) begin miscompares++; $display("FAIL gap_restart_reads: got %0d want %0d", ob_acc, n); end
        vectors++;
        if (ob_done_cyc !== t) begin miscompares++; $display("FAIL gap_restart_done: got %0d want %0d", ob_done_cyc, t); end
        vectors++;
        if (ob_ld !== ld) begin miscompares++; $display("FAIL gap_restart_data: got %0h want %0h", ob_ld, ld); end
    endtask

    task automatic test_busy_start();
        int n, t; bit hit; logic [31:0] ld;
        clear_cfg(); cfg_n = 2; cfg_resp[0] = 32'h0; cfg_resp[1] = 32'h1;
        model(32'h1, 32'h1, 2, 0, n, hit, t, ld);
        run_poll(2'd1, 32'h1, 32'h1, 2, 0, 0, -1, 2);
        vectors++;
        if (ob_addr_bad !== 0) begin miscompares++; $display("FAIL busy_start_addr: got %0d bad cycles want 0", ob_addr_bad); end
        vectors++;
        if (ob_acc !== n) begin miscompares++; $display("FAIL busy_start_reads: got %0d want %0d", ob_acc, n); end
        vectors++;
        if (ob_done_cyc !== t) begin miscompares++; $display("FAIL busy_start_done: got %0d want %0d", ob_done_cyc, t); end
    endtask

    task automatic test_random();
        int n, t, k, iv, mp; bit hit; logic [31:0] ld, m, mt; logic [ADDR_W-1:0] a;
        for (int it = 0; it < 12; it++) begin
            clear_cfg();
            k  = $urandom_range(1, 5);
            m  = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom & 32'h0000_00FF) | 32'h1);
            mt = $urandom;
            for (int i = 0; i < k; i++) begin
                cfg_wait[i] = $urandom_range(0, 3);
                cfg_resp[i] = ($urandom_range(0, 2) == 0) ? ((mt & m) | ($urandom & ~m)) : $urandom;
            end
            cfg_resp[k-1] = (mt & m) | ($urandom & ~m);
            cfg_n = k;
            iv = $urandom_range(0, 5);
            mp = $urandom_range(0, 4);
            a  = ADDR_W'($urandom);
            model(m, mt, iv, mp, n, hit, t, ld);
            run_poll(a, m, mt, iv, mp, 0, -1, -1);
            vectors++;
            if (ob_acc !== n) begin miscompares++; $display("FAIL rand%0d_reads: got %0d want %0d", it, ob_acc, n); end
            vectors++;
            if (ob_done_cnt !== (hit ? 1 : 0) || ob_to_cnt !== (hit ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rand%0d_outcome: got done %0d timeout %0d want hit %0d", it, ob_done_cnt, ob_to_cnt, hit);
            end
            vectors++;
            if ((hit ? ob_done_cyc : ob_to_cyc) !== t) begin
                miscompares++; $display("FAIL rand%0d_end_cycle: got %0d want %0d", it, hit ? ob_done_cyc : ob_to_cyc, t);
            end
            vectors++;
            if (ob_ld !== ld) begin miscompares++; $display("FAIL rand%0d_last_data: got %0h want %0h", it, ob_ld, ld); end
            vectors++;
            if (ob_busy_end !== t + 1) begin miscompares++; $display("FAIL rand%0d_busy_drop: got %0d want %0d", it, ob_busy_end, t + 1); end
            vectors++;
            if (ob_both !== 0 || ob_addr_bad !== 0) begin
                miscompares++; $display("FAIL rand%0d_exclusive_addr: got both %0d addr_bad %0d want 0 0", it, ob_both, ob_addr_bad);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        poll_addr = '0;
        mask = '0;
        match = '0;
        interval = '0;
        max_polls = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        clear_cfg();
        base_acc = 0;
        base_wait = 0;
        test_reset();
        test_single();
        test_retry();
        test_waitreq();
        test_timeout();
        test_reset_gap();
        test_busy_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/soc_system_pio_poll_master.md
SOC_SYSTEM_PIO_POLL_MASTER -- requirements
Module: soc_system_pio_poll_master

Interface
REQ-001 Parameter ADDR_W, default 2: Avalon-MM master address width.
REQ-002 Parameter READ_LATENCY, default 1: fixed slave read latency in cycles, legal range 1..4.
REQ-003 Parameter GAP_W, default 16: width of the inter-poll interval input.
REQ-004 Parameter CNT_W, default 16: width of the poll-attempt limit input and counter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin a poll sequence.
REQ-008 poll_addr  input  ADDR_W  slave address to read; sampled on accepted start.
REQ-009 mask  input  32  bit mask; sampled on accepted start.
REQ-010 match  input  32  expected value under mask; sampled on accepted start.
REQ-011 interval  input  GAP_W  idle cycles between reads; sampled on accepted start.
REQ-012 max_polls  input  CNT_W  read-attempt limit; sampled on accepted start; 0 means unlimited.
REQ-013 avm_address  output  ADDR_W  master address.
REQ-014 avm_read  output  1  master read strobe.
REQ-015 avm_waitrequest  input  1  slave stall; read held while high.
REQ-016 avm_readdata  input  32  slave read data, valid READ_LATENCY cycles after acceptance.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on match.
REQ-019 timeout  output  1  one-cycle pulse on limit reached.
REQ-020 last_data  output  32  most recent captured readdata.

Function
REQ-021 States: IDLE, RD, LAT, CHK, GAP.
REQ-022 IDLE: start=1 latches the configuration inputs, clears the attempt counter, and moves to RD next cycle; start while busy is ignored.
REQ-023 RD: avm_read=1 and avm_address=latched poll_addr; remains in RD while avm_waitrequest=1; on avm_waitrequest=0 the read is accepted, the attempt counter increments, and the FSM moves to LAT.
REQ-024 avm_read is 0 in every state other than RD; avm_address holds the latched value at all times.
REQ-025 LAT: counts READ_LATENCY cycles from acceptance; avm_readdata is captured into last_data in the cycle exactly READ_LATENCY cycles after acceptance, and the FSM moves to CHK.
REQ-026 CHK: if (last_data & mask) == (match & mask), done=1 for that cycle and the FSM moves to IDLE.
REQ-027 CHK, mismatch, limit reached (max_polls!=0 and attempts==max_polls): behaviour per REQ-035/REQ-036.
REQ-028 CHK, mismatch, limit not reached: the FSM moves to GAP with the gap counter loaded with interval; interval=0 moves directly to RD.
REQ-029 GAP: decrements the gap counter each cycle and moves to RD when it reaches 1; total idle cycles between CHK and the next RD equal interval.
REQ-030 mask=0 always matches, giving done after the first read.
REQ-031 The attempt counter saturates at all-ones and does not wrap.
REQ-032 done and timeout are never asserted in the same cycle.

Reset
REQ-033 On reset_n=0, immediately and at any point mid-operation: state=IDLE; avm_read=0; avm_address, last_data, and all counters =0; busy, done, timeout =0.
REQ-034 After deassertion, a start in the first active edge is accepted normally.

Configuration
REQ-035 With POLL_TIMEOUT_EN defined: the limit in REQ-027 is enforced; on limit, timeout=1 for the CHK cycle and the FSM moves to IDLE.
REQ-036 Without POLL_TIMEOUT_EN: max_polls is ignored; polling continues until match; timeout is tied to 0; the attempt counter still increments and saturates.

Verification
REQ-037 Slave returns 0x1 immediately, mask=0x1, match=0x1, READ_LATENCY=1, no wait -> single read, done 3 cycles after start, last_data=0x1.
REQ-038 Slave returns 0x0 for 3 reads then 0x1, interval=4 -> exactly 4 avm_read pulses, each pair separated by 4 idle cycles, done after the 4th read.
REQ-039 avm_waitrequest high 5 cycles on the first read -> avm_read and avm_address stable for 6 cycles; data captured 1 cycle after acceptance.
REQ-040 POLL_TIMEOUT_EN defined, max_polls=3, never match -> 3 reads, timeout pulse, done never asserted, busy=0 next cycle; without the macro -> reads continue and timeout stays 0.
REQ-041 reset_n asserted during GAP -> all outputs 0 asynchronously; a new start then runs a clean sequence.
REQ-042 start pulsed while busy with different poll_addr -> ignored; avm_address keeps its original value.
